// File: rtl/lap_ctrl_pkg.sv
// lap_ctrl_pkg: shared sizes and FSM encoding for the lap memory sequencer
package lap_ctrl_pkg;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int DIGIT_W = 4;
    localparam int DATA_W  = 6 * DIGIT_W;
    localparam int CNT_W   = ADDR_W + 1;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_W_SETUP   = 3'd1;
    localparam logic [2:0] S_W_STROBE  = 3'd2;
    localparam logic [2:0] S_R_SETUP   = 3'd3;
    localparam logic [2:0] S_R_STROBE  = 3'd4;
    localparam logic [2:0] S_R_CAPTURE = 3'd5;
    localparam logic [2:0] S_CLEAR     = 3'd6;
endpackage

// File: rtl/lap_memory_ctrl_rise_detect.sv
// rise_detect: rising-edge detector against the registered previous level
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);
    logic d_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) d_q <= 1'b0;
        else d_q <= d;
    end
    assign rise = d & ~d_q;
endmodule

// File: rtl/lap_memory_ctrl.sv
// lap_memory_ctrl: captures lap times into the register file and reads them back for display
module lap_memory_ctrl
    import lap_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] time_in,
    input  logic              lap_req,
    input  logic              clear_req,
    input  logic              mode_recall,
    input  logic              recall_next,
    input  logic              recall_prev,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              wclk,
    output logic              rclk,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  lap_count,
    output logic              full,
    output logic              lap_drop,
    output logic [DATA_W-1:0] lap_time,
    output logic [ADDR_W-1:0] lap_index,
    output logic              lap_valid,
    output logic              busy
);
    logic [2:0]        state, state_nxt;
    logic [ADDR_W-1:0] rd_idx, rd_nxt, last;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              lap_pend, clr_pend, recall_rise, idle, lap_any, rd_trig, go_clr, go_wr, go_rd;

    rise_detect u_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (mode_recall),
        .rise    (recall_rise)
    );

    always_comb begin
        idle      = state == S_IDLE;
        lap_any   = lap_req | lap_pend;
        last      = ADDR_W'(lap_count - 1'b1);
        rd_trig   = mode_recall && lap_count != '0 && (recall_rise || (recall_next ^ recall_prev));
        go_clr    = idle && (clear_req || clr_pend);
        go_wr     = idle && !go_clr && lap_any && !full;
        go_rd     = idle && !go_clr && !go_wr && rd_trig;
        rd_nxt    = recall_rise ? '0 :
                    recall_next ? (rd_idx == last ? '0 : rd_idx + 1'b1) :
                                  (rd_idx == '0 ? last : rd_idx - 1'b1);
        state_nxt = go_clr                ? S_CLEAR     :
                    go_wr                 ? S_W_SETUP   :
                    go_rd                 ? S_R_SETUP   :
                    state == S_W_SETUP    ? S_W_STROBE  :
                    state == S_R_SETUP    ? S_R_STROBE  :
                    state == S_R_STROBE   ? S_R_CAPTURE : S_IDLE;
        cnt_nxt   = state == S_CLEAR ? '0 : state == S_W_STROBE ? lap_count + 1'b1 : lap_count;
    end

    // the write slot is always lap_count's low bits, so no separate write pointer is kept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            wclk      <= 1'b0;
            rclk      <= 1'b0;
            lap_count <= '0;
            full      <= 1'b0;
            lap_drop  <= 1'b0;
            lap_pend  <= 1'b0;
            clr_pend  <= 1'b0;
            address   <= '0;
            rf_wdata  <= '0;
            rd_idx    <= '0;
            lap_time  <= '0;
            lap_index <= '0;
            lap_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= state_nxt != S_IDLE;
            wclk      <= state == S_W_SETUP;
            rclk      <= state == S_R_SETUP;
            lap_count <= cnt_nxt;
            full      <= cnt_nxt == CNT_W'(DEPTH);
            lap_drop  <= idle ? !go_clr && full && lap_any : lap_req && lap_pend;
            lap_pend  <= go_clr ? 1'b0 : idle ? lap_req && lap_pend && !full : lap_any;
            clr_pend  <= idle ? 1'b0 : clr_pend | clear_req;
            address   <= go_wr ? lap_count[ADDR_W-1:0] : go_rd ? rd_nxt : address;
            rf_wdata  <= go_wr ? time_in : rf_wdata;
            rd_idx    <= state == S_CLEAR ? '0 : go_rd ? rd_nxt : rd_idx;
            lap_time  <= state == S_R_CAPTURE ? rf_rdata : lap_time;
            lap_index <= state == S_R_CAPTURE ? rd_idx : lap_index;
            lap_valid <= (state == S_CLEAR || !mode_recall) ? 1'b0 : state == S_R_CAPTURE ? 1'b1 : lap_valid;
        end
    end
endmodule

// File: tb/tb_lap_memory_ctrl.sv
// tb_lap_memory_ctrl: randomized scenario bench with a behavioural register file and lap model
module tb_lap_memory_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [23:0] time_in = '0, rf_rdata = '0;
    logic        lap_req = 1'b0, clear_req = 1'b0, mode_recall = 1'b0, recall_next = 1'b0, recall_prev = 1'b0;
    logic        wclk, rclk, full, lap_drop, lap_valid, busy;
    logic [3:0]  address, lap_index;
    logic [23:0] rf_wdata, lap_time;
    logic [4:0]  lap_count;

    logic [23:0] mem [16];
    logic [23:0] exp_lap [16];
    int          n_exp = 0, idx = 0;
    int          vectors = 0, miscompares = 0;

    lap_memory_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .time_in     (time_in),
        .lap_req     (lap_req),
        .clear_req   (clear_req),
        .mode_recall (mode_recall),
        .recall_next (recall_next),
        .recall_prev (recall_prev),
        .rf_rdata    (rf_rdata),
        .wclk        (wclk),
        .rclk        (rclk),
        .address     (address),
        .rf_wdata    (rf_wdata),
        .lap_count   (lap_count),
        .full        (full),
        .lap_drop    (lap_drop),
        .lap_time    (lap_time),
        .lap_index   (lap_index),
        .lap_valid   (lap_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // register file: writes on wclk rise, registered read on rclk rise
    always @(posedge wclk) mem[address] <= rf_wdata;
    always @(posedge rclk) rf_rdata <= mem[address];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] rand_bcd();
        logic [23:0] v;
        for (int d = 0; d < 6; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic do_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        n_exp = 0;
    endtask

    task automatic store(input logic [23:0] t);
        time_in = t;
        lap_req = 1'b1;
        tick();
        lap_req = 1'b0;
        repeat (2) tick();
        exp_lap[n_exp] = t;
        n_exp++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({wclk, rclk, address, rf_wdata, lap_count, full, lap_drop, lap_time, lap_index, lap_valid, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got wclk=%b rclk=%b addr=%h cnt=%0d busy=%b valid=%b, want all 0", wclk, rclk, address, lap_count, busy, lap_valid);
        end
        reset_n = 1'b1;
        tick();
        vectors++;
        if ({busy, lap_count, full} !== '0) begin
            miscompares++;
            $display("FAIL reset_release: got busy=%b cnt=%0d full=%b, want 0", busy, lap_count, full);
        end
    endtask

    task automatic test_first_write();
        time_in = 24'h012345;
        lap_req = 1'b1;
        tick();
        lap_req = 1'b0;
        vectors++;
        if ({busy, wclk, address, rf_wdata} !== {1'b1, 1'b0, 4'd0, 24'h012345}) begin
            miscompares++;
            $display("FAIL write_setup: got busy=%b wclk=%b addr=%h wdata=%h, want 1 0 0 012345", busy, wclk, address, rf_wdata);
        end
        tick();
        vectors++;
        if ({wclk, address, rf_wdata} !== {1'b1, 4'd0, 24'h012345}) begin
            miscompares++;
            $display("FAIL write_strobe: got wclk=%b addr=%h wdata=%h, want 1 0 012345", wclk, address, rf_wdata);
        end
        tick();
        vectors++;
        if ({lap_count, busy, wclk, full} !== {5'd1, 3'b000}) begin
            miscompares++;
            $display("FAIL write_done: got cnt=%0d busy=%b wclk=%b full=%b, want 1 0 0 0", lap_count, busy, wclk, full);
        end
    endtask

    task automatic test_fill();
        logic [23:0] t;
        logic        exp_drop;
        do_clear();
        for (int i = 0; i < 17; i++) begin
            t = rand_bcd();
            exp_drop = n_exp == 16;
            time_in = t;
            lap_req = 1'b1;
            tick();
            lap_req = 1'b0;
            vectors++;
            if (lap_drop !== exp_drop) begin
                miscompares++;
                $display("FAIL fill_drop[%0d]: got %b want %b", i, lap_drop, exp_drop);
            end
            tick();
            vectors++;
            if ({wclk, lap_drop} !== {!exp_drop, 1'b0}) begin
                miscompares++;
                $display("FAIL fill_strobe[%0d]: got wclk=%b drop=%b want %b 0", i, wclk, lap_drop, !exp_drop);
            end
            tick();
            if (!exp_drop) begin
                exp_lap[n_exp] = t;
                n_exp++;
            end
            vectors++;
            if ({lap_count, full} !== {5'(n_exp), n_exp == 16}) begin
                miscompares++;
                $display("FAIL fill_count[%0d]: got cnt=%0d full=%b want %0d %b", i, lap_count, full, n_exp, n_exp == 16);
            end
        end
        for (int s = 0; s < 16; s++) begin
            vectors++;
            if (mem[s] !== exp_lap[s]) begin
                miscompares++;
                $display("FAIL fill_slot[%0d]: got %h want %h", s, mem[s], exp_lap[s]);
            end
        end
    endtask

    task automatic test_recall();
        int dirs [12];
        do_clear();
        for (int i = 0; i < 3; i++) store(rand_bcd());
        mode_recall = 1'b1;
        idx = 0;
        tick();
        vectors++;
        if ({busy, address} !== {1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL recall_setup: got busy=%b addr=%h want 1 0", busy, address);
        end
        tick();
        vectors++;
        if (rclk !== 1'b1) begin
            miscompares++;
            $display("FAIL recall_rclk: got %b want 1", rclk);
        end
        repeat (2) tick();
        vectors++;
        if ({lap_valid, lap_index, lap_time} !== {1'b1, 4'(idx), exp_lap[idx]}) begin
            miscompares++;
            $display("FAIL recall_first: got valid=%b idx=%0d time=%h want 1 %0d %h", lap_valid, lap_index, lap_time, idx, exp_lap[idx]);
        end
        dirs[0] = 1; dirs[1] = 1; dirs[2] = 1; dirs[3] = 0;
        for (int i = 4; i < 12; i++) dirs[i] = int'($urandom_range(0, 1));
        for (int i = 0; i < 12; i++) begin
            recall_next = dirs[i] == 1;
            recall_prev = dirs[i] == 0;
            tick();
            recall_next = 1'b0;
            recall_prev = 1'b0;
            idx = dirs[i] == 1 ? (idx + 1) % n_exp : (idx + n_exp - 1) % n_exp;
            repeat (3) tick();
            vectors++;
            if ({lap_valid, lap_index, lap_time} !== {1'b1, 4'(idx), exp_lap[idx]}) begin
                miscompares++;
                $display("FAIL recall_step[%0d]: got valid=%b idx=%0d time=%h want 1 %0d %h", i, lap_valid, lap_index, lap_time, idx, exp_lap[idx]);
            end
        end
        recall_next = 1'b1;
        recall_prev = 1'b1;
        tick();
        recall_next = 1'b0;
        recall_prev = 1'b0;
        vectors++;
        if ({busy, lap_index} !== {1'b0, 4'(idx)}) begin
            miscompares++;
            $display("FAIL recall_both: got busy=%b idx=%0d want 0 %0d", busy, lap_index, idx);
        end
        tick();
    endtask

    task automatic test_lap_during_read();
        logic [23:0] t;
        int          k;
        t = rand_bcd();
        recall_next = 1'b1;
        tick();
        recall_next = 1'b0;
        idx = (idx + 1) % n_exp;
        time_in = t;
        lap_req = 1'b1;
        tick();
        lap_req = 1'b0;
        exp_lap[n_exp] = t;
        n_exp++;
        k = 0;
        while (lap_count !== 5'(n_exp) && k < 20) begin
            tick();
            k++;
        end
        vectors++;
        if (lap_count !== 5'(n_exp)) begin
            miscompares++;
            $display("FAIL pend_count: got %0d want %0d within 20 cycles", lap_count, n_exp);
        end
        vectors++;
        if ({lap_valid, lap_index, lap_time, mem[n_exp-1]} !== {1'b1, 4'(idx), exp_lap[idx], t}) begin
            miscompares++;
            $display("FAIL pend_data: got idx=%0d time=%h slot=%h want %0d %h %h", lap_index, lap_time, mem[n_exp-1], idx, exp_lap[idx], t);
        end
        mode_recall = 1'b0;
        tick();
        vectors++;
        if ({lap_valid, lap_count} !== {1'b0, 5'(n_exp)}) begin
            miscompares++;
            $display("FAIL recall_exit: got valid=%b cnt=%0d want 0 %0d", lap_valid, lap_count, n_exp);
        end
    endtask

    task automatic test_clear_with_lap();
        logic seen;
        seen = 1'b0;
        time_in = rand_bcd();
        lap_req = 1'b1;
        clear_req = 1'b1;
        tick();
        lap_req = 1'b0;
        clear_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | wclk | lap_drop;
            tick();
        end
        n_exp = 0;
        vectors++;
        if ({seen, lap_count, full, lap_valid, busy} !== '0) begin
            miscompares++;
            $display("FAIL clear_lap: got strobe_or_drop=%b cnt=%0d full=%b valid=%b busy=%b want all 0", seen, lap_count, full, lap_valid, busy);
        end
    endtask

    task automatic test_empty_recall();
        logic seen;
        seen = 1'b0;
        mode_recall = 1'b1;
        tick();
        recall_next = 1'b1;
        tick();
        recall_next = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | rclk | busy;
            tick();
        end
        vectors++;
        if ({seen, lap_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL empty_recall: got read_activity=%b valid=%b want 0 0", seen, lap_valid);
        end
        mode_recall = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        logic [23:0] t;
        t = rand_bcd();
        time_in = t;
        lap_req = 1'b1;
        tick();
        lap_req = 1'b0;
        tick();
        vectors++;
        if (wclk !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_strobe: got wclk=%b want 1", wclk);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({wclk, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_async: got wclk=%b busy=%b want 0 0", wclk, busy);
        end
        tick();
        reset_n = 1'b1;
        tick();
        vectors++;
        if ({lap_count, full, busy, mem[0]} !== {7'd0, t}) begin
            miscompares++;
            $display("FAIL midrst_count: got cnt=%0d full=%b busy=%b slot0=%h want 0 0 0 %h", lap_count, full, busy, mem[0], t);
        end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_fill();
        test_recall();
        test_lap_during_read();
        test_clear_with_lap();
        test_empty_recall();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
